// File: rtl/lsu_req_queue.sv
// lsu_req_queue: EX/MEM load/store issue unit with in-order outstanding queue.
// Ports: op_* in / op_ready out, ale_* out, data_sram_* port, resp_* out.
module lsu_req_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_store,
  input  logic [1:0]        op_size,
  input  logic              op_unsigned,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  input  logic [4:0]        op_dest,
  input  logic              flush,
  output logic              ale_valid,
  output logic [ADDR_W-1:0] ale_badv,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic              resp_valid,
  output logic              resp_store,
  output logic [4:0]        resp_dest,
  output logic [31:0]       resp_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  typedef struct packed {
    logic       store;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic [4:0] dest;
    logic       cancel;
  } ent_t;

  logic              r_req_pending;
  logic [ADDR_W-1:0] r_req_addr;
  logic [1:0]        r_req_size;
  logic              r_req_wr;
  logic [3:0]        r_req_wstrb;
  logic [31:0]       r_req_wdata;
  logic              r_req_uns;
  logic [4:0]        r_req_dest;
  logic              r_req_cancel;

  ent_t              r_q [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_mis;
  logic              w_accept;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [CW:0]       w_occ;
  logic [31:0]       w_wdata;
  logic [3:0]        w_wstrb;
  ent_t              w_head;
  ent_t              w_push_ent;
  logic [7:0]        w_b;
  logic [15:0]       w_h;
  logic [31:0]       w_ld;

  function automatic logic [PW-1:0] f_nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_mis = 1'b0;
    case (op_size)
      2'd0:    w_mis = 1'b0;
      2'd1:    w_mis = op_addr[0];
      default: w_mis = |op_addr[1:0];
    endcase
  end

  // Pending request counts against capacity until it reaches the queue.
  assign w_occ    = {1'b0, r_count} + (CW + 1)'(r_req_pending);
  assign op_ready = ~flush
                  & (~r_req_pending | data_sram_addr_ok)
                  & (w_occ < DEPTH_L);
  assign w_accept = op_valid & op_ready;
  assign w_issue  = w_accept & ~w_mis;

  assign ale_valid = w_accept & w_mis;
  assign ale_badv  = ale_valid ? op_addr : '0;

  always_comb begin
    w_wdata = op_wdata;
    w_wstrb = 4'b1111;
    case (op_size)
      2'd0: begin
        w_wdata = {4{op_wdata[7:0]}};
        w_wstrb = 4'b0001 << op_addr[1:0];
      end
      2'd1: begin
        w_wdata = {2{op_wdata[15:0]}};
        w_wstrb = op_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!op_store) w_wstrb = 4'b0000;
  end

  assign w_push = r_req_pending & data_sram_addr_ok;
  assign w_pop  = data_sram_data_ok & (r_count != '0);

  // A request caught in a flush must still complete its handshake,
  // so it is neutered to a read with no strobes and marked cancelled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_req_pending <= 1'b0;
      r_req_addr    <= '0;
      r_req_size    <= '0;
      r_req_wr      <= 1'b0;
      r_req_wstrb   <= '0;
      r_req_wdata   <= '0;
      r_req_uns     <= 1'b0;
      r_req_dest    <= '0;
      r_req_cancel  <= 1'b0;
    end else if (w_issue) begin
      r_req_pending <= 1'b1;
      r_req_addr    <= op_addr;
      r_req_size    <= op_size;
      r_req_wr      <= op_store;
      r_req_wstrb   <= w_wstrb;
      r_req_wdata   <= w_wdata;
      r_req_uns     <= op_unsigned;
      r_req_dest    <= op_dest;
      r_req_cancel  <= 1'b0;
    end else if (w_push) begin
      r_req_pending <= 1'b0;
    end else if (flush && r_req_pending) begin
      r_req_wstrb   <= 4'b0000;
      r_req_wr      <= 1'b0;
      r_req_cancel  <= 1'b1;
    end
  end

  assign w_push_ent = '{
    store:  r_req_wr,
    size:   r_req_size,
    uns:    r_req_uns,
    off:    r_req_addr[1:0],
    dest:   r_req_dest,
    cancel: r_req_cancel | flush
  };

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) r_q[i].cancel <= 1'b1;
      end
      if (w_push) begin
        r_q[r_tail] <= w_push_ent;
        r_tail      <= f_nxt(r_tail);
      end
      if (w_pop) r_head <= f_nxt(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign w_head = r_q[r_head];
  assign w_b    = data_sram_rdata[{w_head.off, 3'b000} +: 8];
  assign w_h    = data_sram_rdata[{w_head.off[1], 4'b0000} +: 16];

  always_comb begin
    w_ld = data_sram_rdata;
    case (w_head.size)
      2'd0:    w_ld = {{24{~w_head.uns & w_b[7]}}, w_b};
      2'd1:    w_ld = {{16{~w_head.uns & w_h[15]}}, w_h};
      default: ;
    endcase
  end

  assign resp_valid = w_pop & ~w_head.cancel;
  assign resp_store = resp_valid & w_head.store;
  assign resp_dest  = (resp_valid & ~w_head.store) ? w_head.dest : '0;
  assign resp_data  = (resp_valid & ~w_head.store) ? w_ld : '0;

  assign data_sram_req   = r_req_pending;
  assign data_sram_wr    = r_req_wr;
  assign data_sram_size  = r_req_size;
  assign data_sram_wstrb = r_req_wstrb;
  assign data_sram_addr  = r_req_addr;
  assign data_sram_wdata = r_req_wdata;

endmodule
